// File: rtl/vn_lut_pkg.sv
// Shared constants and FSM encoding for the VN IB-LUT bank loader.
// Optional feature macro: VN_LUT_LOADER_CKSUM_EN (checksum width lives here).
package vn_lut_pkg;

  localparam int unsigned DEF_MSG_BITWIDTH       = 3;
  localparam int unsigned DEF_PAGE_ADDR_BITWIDTH = 5;
  localparam int unsigned DEF_VN_LOAD_CYCLE      = 32;
  localparam int unsigned CKSUM_W                = 8;

  typedef logic [1:0] lut_state_t;

  localparam lut_state_t ST_IDLE = 2'd0;
  localparam lut_state_t ST_LOAD = 2'd1;
  localparam lut_state_t ST_FULL = 2'd2;

endpackage

// File: rtl/vn_lut_bank_loader_if.sv
// Stream-in / LUT-write bundle of the VN LUT bank loader.
// slave  : the loader (consumes *_i, drives *_o)
// master : the feeder/decoder side (drives *_i, observes *_o)
// Macro VN_LUT_LOADER_CKSUM_EN adds expected_cksum_i / cksum_err_o.
interface vn_lut_bank_loader_if
  import vn_lut_pkg::*;
#(
  parameter int unsigned MSG_W  = DEF_MSG_BITWIDTH,
  parameter int unsigned ADDR_W = DEF_PAGE_ADDR_BITWIDTH + 1
) ();

  logic              load_start_i;
  logic [MSG_W-1:0]  entry_i;
  logic              entry_valid_i;
  logic              entry_ready_o;
  logic              bank_swap_i;
  logic [MSG_W-1:0]  lut_in_o;
  logic [ADDR_W-1:0] write_addr_o;
  logic              we_o;
  logic              active_bank_o;
  logic              load_busy_o;
  logic              shadow_full_o;
  logic              load_done_o;
`ifdef VN_LUT_LOADER_CKSUM_EN
  logic [CKSUM_W-1:0] expected_cksum_i;
  logic               cksum_err_o;
`endif

  modport slave (
    input  load_start_i, entry_i, entry_valid_i, bank_swap_i,
`ifdef VN_LUT_LOADER_CKSUM_EN
    input  expected_cksum_i,
    output cksum_err_o,
`endif
    output entry_ready_o, lut_in_o, write_addr_o, we_o,
    output active_bank_o, load_busy_o, shadow_full_o, load_done_o
  );

  modport master (
    output load_start_i, entry_i, entry_valid_i, bank_swap_i,
`ifdef VN_LUT_LOADER_CKSUM_EN
    output expected_cksum_i,
    input  cksum_err_o,
`endif
    input  entry_ready_o, lut_in_o, write_addr_o, we_o,
    input  active_bank_o, load_busy_o, shadow_full_o, load_done_o
  );

endinterface

// File: rtl/vn_lut_page_counter.sv
// Modulo-MODULUS page counter with synchronous clear (priority) and enable.
// Ports: clk, rst (async active-high), clr_i, en_i, cnt_o (registered),
//        last_c (combinational: counter sits at MODULUS-1).
module vn_lut_page_counter
  import vn_lut_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_PAGE_ADDR_BITWIDTH,
  parameter int unsigned MODULUS = DEF_VN_LOAD_CYCLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             last_c
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign last_c = (cnt_q == WIDTH'(MODULUS - 1));

  // Wraps at MODULUS-1, which may be below the natural 2**WIDTH-1 rollover.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (en_i)   cnt_d = last_c ? '0 : cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vn_lut_bank_loader.sv
// VN IB-LUT bank loader: takes a valid/ready stream of LUT entries and writes
// them into the shadow half ({~active_bank, page}) of a double-banked LUT,
// granting a bank swap only once the shadow half is completely loaded.
// Ports: sys_clk, rst (async active-high), bus (vn_lut_bank_loader_if.slave).
// Macro VN_LUT_LOADER_CKSUM_EN: mod-256 checksum of the loaded bank; a mismatch
// on the final entry raises sticky cksum_err_o and withholds the FULL state.
module vn_lut_bank_loader
  import vn_lut_pkg::*;
#(
  parameter int unsigned MSG_BITWIDTH       = DEF_MSG_BITWIDTH,
  parameter int unsigned VN_LOAD_CYCLE      = DEF_VN_LOAD_CYCLE,
  parameter int unsigned PAGE_ADDR_BITWIDTH = DEF_PAGE_ADDR_BITWIDTH
) (
  input logic                 sys_clk,
  input logic                 rst,
  vn_lut_bank_loader_if.slave bus
);

  localparam int unsigned ADDR_W = PAGE_ADDR_BITWIDTH + 1;

  lut_state_t              state_q, state_d;
  logic                    active_q, active_d;
  logic                    busy_q, busy_d;
  logic                    full_q, full_d;
  logic                    we_q, we_d;
  logic                    done_q, done_d;
  logic [MSG_BITWIDTH-1:0] lut_q, lut_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;

  logic [PAGE_ADDR_BITWIDTH-1:0] page_cnt;
  logic                          last_page_c;
  logic                          hs_c;
  logic                          cksum_bad_c;

  // A restart pulse discards any handshake presented in the same cycle.
  assign hs_c = (state_q == ST_LOAD) & bus.entry_valid_i & ~bus.load_start_i;

  vn_lut_page_counter #(
    .WIDTH   (PAGE_ADDR_BITWIDTH),
    .MODULUS (VN_LOAD_CYCLE)
  ) u_page_cnt (
    .clk    (sys_clk),
    .rst    (rst),
    .clr_i  (bus.load_start_i),
    .en_i   (hs_c),
    .cnt_o  (page_cnt),
    .last_c (last_page_c)
  );

`ifdef VN_LUT_LOADER_CKSUM_EN
  logic [CKSUM_W-1:0] sum_q, sum_d, sum_next_c;
  logic               err_q, err_d;

  assign sum_next_c  = sum_q + CKSUM_W'(bus.entry_i);
  assign cksum_bad_c = (sum_next_c != bus.expected_cksum_i);

  // Running sum of accepted entries; error is sticky until the next load.
  always_comb begin
    sum_d = sum_q;
    err_d = err_q;
    if (bus.load_start_i) begin
      sum_d = '0;
      err_d = 1'b0;
    end else if (hs_c) begin
      sum_d = sum_next_c;
      if (last_page_c && cksum_bad_c) err_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign bus.cksum_err_o = err_q;
`else
  assign cksum_bad_c = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    lut_d    = lut_q;
    addr_d   = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.load_start_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // bank_swap_i is deliberately not looked at: a partial bank never goes live.
        if (hs_c) begin
          we_d   = 1'b1;
          lut_d  = bus.entry_i;
          addr_d = {~active_q, page_cnt};
          if (last_page_c) begin
            done_d  = 1'b1;
            state_d = cksum_bad_c ? ST_IDLE : ST_FULL;
          end
        end
      end
      ST_FULL: begin
        // Swap takes precedence; a simultaneous start then loads the new shadow.
        if (bus.bank_swap_i) begin
          active_d = ~active_q;
          state_d  = bus.load_start_i ? ST_LOAD : ST_IDLE;
        end else if (bus.load_start_i) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_LOAD);
    full_d = (state_d == ST_FULL);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      full_q   <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      lut_q    <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      full_q   <= full_d;
      we_q     <= we_d;
      done_q   <= done_d;
      lut_q    <= lut_d;
      addr_q   <= addr_d;
    end
  end

  assign bus.entry_ready_o = busy_q;
  assign bus.load_busy_o   = busy_q;
  assign bus.shadow_full_o = full_q;
  assign bus.active_bank_o = active_q;
  assign bus.we_o          = we_q;
  assign bus.load_done_o   = done_q;
  assign bus.lut_in_o      = lut_q;
  assign bus.write_addr_o  = addr_q;

endmodule

// File: tb/tb_vn_lut_bank_loader.sv
// Bench for vn_lut_bank_loader: a directed vector table for the basic
// load/swap flow, hand sequences for the multi-cycle corners, then random
// stimulus against a transaction-level reference model.
// Macro VN_LUT_LOADER_CKSUM_EN enables the checksum sequences.
module tb_vn_lut_bank_loader;
  import vn_lut_pkg::*;

  localparam int unsigned MSG_W  = DEF_MSG_BITWIDTH;
  localparam int unsigned ADDR_W = DEF_PAGE_ADDR_BITWIDTH + 1;
  localparam int          VN     = DEF_VN_LOAD_CYCLE;

  logic sys_clk = 1'b0;
  logic rst;
  always #5 sys_clk = ~sys_clk;

  vn_lut_bank_loader_if #(.MSG_W(MSG_W), .ADDR_W(ADDR_W)) bus ();

  vn_lut_bank_loader #(
    .MSG_BITWIDTH       (DEF_MSG_BITWIDTH),
    .VN_LOAD_CYCLE      (DEF_VN_LOAD_CYCLE),
    .PAGE_ADDR_BITWIDTH (DEF_PAGE_ADDR_BITWIDTH)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  int n_writes;

  // ---------------- reference model (loaded-page count + bank bit) -----------
  int   m_mode;    // 0 idle, 1 loading, 2 shadow full
  int   m_loaded;  // entries accepted in the current load
  int   m_active;  // bank the decoder reads
  int   m_sum;
  logic m_err;
  int   m_exp_ck;
  logic e_we, e_done;
  int   e_addr, e_lut;

  task automatic model_reset();
    m_mode = 0; m_loaded = 0; m_active = 0; m_sum = 0; m_err = 1'b0;
    e_we = 1'b0; e_done = 1'b0; e_addr = 0; e_lut = 0;
  endtask

  task automatic model_step(input logic ls, input logic v, input int e, input logic sw);
    e_we = 1'b0;
    e_done = 1'b0;
    if (ls) begin m_sum = 0; m_err = 1'b0; end
    case (m_mode)
      0: if (ls) begin m_mode = 1; m_loaded = 0; end
      1: begin
        if (ls) m_loaded = 0;
        else if (v) begin
          e_we   = 1'b1;
          e_addr = (1 - m_active) * VN + m_loaded;
          e_lut  = e;
          m_sum  = m_sum + e;
          m_loaded++;
          if (m_loaded == VN) begin
            e_done = 1'b1;
            m_loaded = 0;
            m_mode = 2;
`ifdef VN_LUT_LOADER_CKSUM_EN
            if ((m_sum % 256) != m_exp_ck) begin m_mode = 0; m_err = 1'b1; end
`endif
          end
        end
      end
      default: begin
        if (sw) begin
          m_active = 1 - m_active;
          m_mode = ls ? 1 : 0;
          m_loaded = 0;
        end else if (ls) begin
          m_mode = 1;
          m_loaded = 0;
        end
      end
    endcase
  endtask

  task automatic check_model(input string name);
    logic ok;
    logic x_busy, x_full;
    x_busy = (m_mode == 1);
    x_full = (m_mode == 2);
    ok = (bus.we_o == e_we) && (bus.load_done_o == e_done) &&
         (bus.active_bank_o == m_active[0]) && (bus.load_busy_o == x_busy) &&
         (bus.entry_ready_o == x_busy) && (bus.shadow_full_o == x_full) &&
         (!e_we || ((bus.write_addr_o == ADDR_W'(e_addr)) && (bus.lut_in_o == MSG_W'(e_lut))));
`ifdef VN_LUT_LOADER_CKSUM_EN
    ok = ok && (bus.cksum_err_o == m_err);
`endif
    if (bus.we_o) n_writes++;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s t=%0t: got we=%0b addr=%0h lut=%0d done=%0b act=%0b busy=%0b rdy=%0b full=%0b, want we=%0b addr=%0h lut=%0d done=%0b act=%0b busy=%0b full=%0b err=%0b",
               name, $time, bus.we_o, bus.write_addr_o, bus.lut_in_o, bus.load_done_o,
               bus.active_bank_o, bus.load_busy_o, bus.entry_ready_o, bus.shadow_full_o,
               e_we, e_addr, e_lut, e_done, m_active, x_busy, x_full, m_err);
    end
  endtask

  task automatic drive(input logic ls, input logic v, input int e, input logic sw);
    @(negedge sys_clk);
    bus.load_start_i  = ls;
    bus.entry_valid_i = v;
    bus.entry_i       = MSG_W'(e);
    bus.bank_swap_i   = sw;
  endtask

  task automatic step(input string name, input logic ls, input logic v, input int e, input logic sw);
    drive(ls, v, e, sw);
    model_step(ls, v, e, sw);
    @(posedge sys_clk);
    #1;
    check_model(name);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    check_model("reset_state");
    @(negedge sys_clk);
    rst = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic              ls;
    logic              v;
    logic [MSG_W-1:0]  e;
    logic              sw;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [MSG_W-1:0]  lut;
    logic              done;
    logic              act;
    logic              busy;
    logic              full;
  } vec_t;

  vec_t tbl[80];
  int   n_vec;

  function automatic vec_t mk(input int ls, input int v, input int e, input int sw,
                              input int we, input int addr, input int lut,
                              input int done, input int act, input int busy, input int full);
    vec_t r;
    r.ls = 1'(ls); r.v = 1'(v); r.e = MSG_W'(e); r.sw = 1'(sw);
    r.we = 1'(we); r.addr = ADDR_W'(addr); r.lut = MSG_W'(lut);
    r.done = 1'(done); r.act = 1'(act); r.busy = 1'(busy); r.full = 1'(full);
    return r;
  endfunction

  initial begin
    logic ok;
    bus.load_start_i  = 1'b0;
    bus.entry_valid_i = 1'b0;
    bus.entry_i       = '0;
    bus.bank_swap_i   = 1'b0;
`ifdef VN_LUT_LOADER_CKSUM_EN
    bus.expected_cksum_i = 8'h70;   // four passes over 0..7
    m_exp_ck = 'h70;
`else
    m_exp_ck = 0;
`endif
    rst = 1'b0;

    // Bank 1 loaded with 0..7 repeating, swap, then bank 0 loaded with 7..0.
    n_vec = 0;
    tbl[n_vec++] = mk(0,0,0,1, 0,0,0, 0,0,0,0);            // swap in IDLE ignored
    tbl[n_vec++] = mk(1,0,0,0, 0,0,0, 0,0,1,0);
    for (int i = 0; i < VN; i++)
      tbl[n_vec++] = mk(0,1,i%8,0, 1,32+i,i%8, int'(i==VN-1),0,int'(i!=VN-1),int'(i==VN-1));
    tbl[n_vec++] = mk(0,0,0,1, 0,0,0, 0,1,0,0);            // swap granted
    tbl[n_vec++] = mk(0,0,0,1, 0,0,0, 0,1,0,0);            // idle swap ignored
    tbl[n_vec++] = mk(1,0,0,0, 0,0,0, 0,1,1,0);
    for (int i = 0; i < VN; i++)
      tbl[n_vec++] = mk(0,1,7-i%8,0, 1,i,7-i%8, int'(i==VN-1),1,int'(i!=VN-1),int'(i==VN-1));
    tbl[n_vec++] = mk(0,0,0,1, 0,0,0, 0,0,0,0);

    do_reset();
    for (int i = 0; i < n_vec; i++) begin
      drive(tbl[i].ls, tbl[i].v, int'(tbl[i].e), tbl[i].sw);
      @(posedge sys_clk);
      #1;
      ok = (bus.we_o == tbl[i].we) && (bus.load_done_o == tbl[i].done) &&
           (bus.active_bank_o == tbl[i].act) && (bus.load_busy_o == tbl[i].busy) &&
           (bus.entry_ready_o == tbl[i].busy) && (bus.shadow_full_o == tbl[i].full) &&
           (!tbl[i].we || ((bus.write_addr_o == tbl[i].addr) && (bus.lut_in_o == tbl[i].lut)));
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL vec%0d: got we=%0b addr=%0h lut=%0d done=%0b act=%0b busy=%0b full=%0b, want we=%0b addr=%0h lut=%0d done=%0b act=%0b busy=%0b full=%0b",
                 i, bus.we_o, bus.write_addr_o, bus.lut_in_o, bus.load_done_o, bus.active_bank_o,
                 bus.load_busy_o, bus.shadow_full_o, tbl[i].we, tbl[i].addr, tbl[i].lut,
                 tbl[i].done, tbl[i].act, tbl[i].busy, tbl[i].full);
      end
    end

    // ---------------- hand sequences against the model ----------------
`ifdef VN_LUT_LOADER_CKSUM_EN
    bus.expected_cksum_i = 8'hA0;   // 32 x 5
    m_exp_ck = 'hA0;
`endif
    do_reset();

    // Valid every other cycle: exactly VN writes, no gaps.
    step("toggle_start", 1'b1, 1'b0, 5, 1'b0);
    n_writes = 0;
    for (int k = 0; k < 2 * VN; k++) step("toggle", 1'b0, 1'(k % 2 == 0), 5, 1'b0);
    check_int("toggle_writes", n_writes, VN);
    step("toggle_swap", 1'b0, 1'b0, 0, 1'b1);

    // Swap request at entry 10 is ignored while loading.
    step("swap10_start", 1'b1, 1'b0, 5, 1'b0);
    for (int k = 0; k < 10; k++) step("swap10_pre", 1'b0, 1'b1, 5, 1'b0);
    step("swap10_req", 1'b0, 1'b1, 5, 1'b1);
    for (int k = 0; k < VN - 11; k++) step("swap10_post", 1'b0, 1'b1, 5, 1'b0);

    // Restart at entry 20 (from FULL, same shadow); the coincident entry is dropped.
    step("restart_start", 1'b1, 1'b0, 5, 1'b0);
    for (int k = 0; k < 20; k++) step("restart_pre", 1'b0, 1'b1, 5, 1'b0);
    step("restart_pulse", 1'b1, 1'b1, 5, 1'b0);
    n_writes = 0;
    for (int k = 0; k < VN; k++) step("restart_post", 1'b0, 1'b1, 5, 1'b0);
    check_int("restart_writes", n_writes, VN);

    // Swap and start together: swap first, then load the old active bank.
    step("swap_start", 1'b1, 1'b0, 5, 1'b1);
    for (int k = 0; k < VN; k++) step("swap_start_load", 1'b0, 1'b1, 5, 1'b0);
    step("swap_again", 1'b0, 1'b0, 0, 1'b1);

    // Async reset in the middle of a load, right after a write.
    step("pre_rst_start", 1'b1, 1'b0, 5, 1'b0);
    for (int k = 0; k < 5; k++) step("pre_rst_load", 1'b0, 1'b1, 5, 1'b0);
    check_int("pre_rst_active", int'(bus.active_bank_o), 1);
    rst = 1'b1;
    #1;
    check_int("async_rst_we", int'(bus.we_o), 0);
    check_int("async_rst_active", int'(bus.active_bank_o), 0);
    check_int("async_rst_busy", int'(bus.load_busy_o), 0);
    #2;
    rst = 1'b0;
    model_reset();

    // ---------------- randomized stimulus ----------------
    for (int k = 0; k < 1500; k++) begin
      step("random",
           1'($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)),
           1'($urandom_range(0, 7) == 0));
    end

`ifdef VN_LUT_LOADER_CKSUM_EN
    // Matching checksum reaches FULL; mismatching one lands in IDLE with swap blocked.
    do_reset();
    bus.expected_cksum_i = 8'hA0;
    m_exp_ck = 'hA0;
    step("ck_ok_start", 1'b1, 1'b0, 5, 1'b0);
    for (int k = 0; k < VN; k++) step("ck_ok_load", 1'b0, 1'b1, 5, 1'b0);
    check_int("ck_ok_err", int'(bus.cksum_err_o), 0);
    check_int("ck_ok_full", int'(bus.shadow_full_o), 1);
    step("ck_ok_swap", 1'b0, 1'b0, 0, 1'b1);
    bus.expected_cksum_i = 8'hA1;
    m_exp_ck = 'hA1;
    step("ck_bad_start", 1'b1, 1'b0, 5, 1'b0);
    for (int k = 0; k < VN; k++) step("ck_bad_load", 1'b0, 1'b1, 5, 1'b0);
    check_int("ck_bad_err", int'(bus.cksum_err_o), 1);
    check_int("ck_bad_full", int'(bus.shadow_full_o), 0);
    step("ck_bad_swap", 1'b0, 1'b0, 0, 1'b1);
    check_int("ck_bad_active", int'(bus.active_bank_o), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vn_lut_bank_loader.md
Name: vn_lut_bank_loader

Overview:
- Upstream write-side feeder for the VN IB-LUT memory cells. Drives their lut_in / write_addr / we ports.
- Accepts a valid/ready stream of quantised LUT entries and writes them into the shadow half of the double-banked LUT address space. Address MSB is the bank select.
- The decoder keeps reading the active half throughout. A bank swap is granted only once the shadow half is fully loaded.

Parameters:
- MSG_BITWIDTH, 3, bit width per LUT entry.
- VN_LOAD_CYCLE, 32, entries per bank (pages); must be ≤ 2**PAGE_ADDR_BITWIDTH.
- PAGE_ADDR_BITWIDTH, 5, page address width; LUT address width = PAGE_ADDR_BITWIDTH+1.

Ports:
- sys_clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- load_start_i  in  1  one-cycle pulse: begin loading the shadow bank.
- entry_i  in  MSG_BITWIDTH  LUT entry data.
- entry_valid_i  in  1  entry_i valid.
- entry_ready_o  out  1  loader accepts entry this cycle.
- bank_swap_i  in  1  decoder iteration-boundary pulse requesting bank swap.
- lut_in_o  out  MSG_BITWIDTH  write data to LUT cell.
- write_addr_o  out  PAGE_ADDR_BITWIDTH+1  {shadow_bank, page}.
- we_o  out  1  write enable to LUT cell.
- active_bank_o  out  1  bank the decoder reads (read_addr MSB).
- load_busy_o  out  1  high in LOAD state.
- shadow_full_o  out  1  high in FULL state.
- load_done_o  out  1  one-cycle pulse on final write.

Behaviour:
- Interface: one clock (sys_clk); reset is asynchronous and active-high (rst).
- Reset: state=IDLE, page counter=0, active_bank_o=0. All other outputs 0.
- FSM states: IDLE, LOAD, FULL.
- IDLE:
  - entry_ready_o=0.
  - load_start_i → LOAD, page counter cleared.
  - bank_swap_i ignored.
- LOAD:
  - entry_ready_o=1.
  - Handshake = entry_valid_i & entry_ready_o.
  - Each handshake registers lut_in_o=entry_i and write_addr_o={~active_bank_o, cnt}, with we_o=1 the following cycle (latency 1). Counter increments.
  - we_o=0 in every cycle with no prior handshake.
  - Handshake at cnt=VN_LOAD_CYCLE-1 → FULL, counter wraps to 0. load_done_o pulses coincident with that final we_o.
  - load_start_i in LOAD restarts: counter=0, any same-cycle handshake is discarded (no write).
  - bank_swap_i in LOAD is ignored; the partial bank is never exposed.
- FULL:
  - entry_ready_o=0, shadow_full_o=1.
  - bank_swap_i → active_bank_o toggles next cycle; state → IDLE.
  - load_start_i alone → LOAD (reloads the same shadow, counter=0).
  - load_start_i with bank_swap_i in the same cycle → swap first, then LOAD into the new shadow (the old active bank).
- Read side: the block never drives read addresses; active_bank_o is the only read-side output.
- Reset mid-LOAD: partial contents abandoned, active_bank_o=0, we_o=0 immediately (async).
- Counter width: PAGE_ADDR_BITWIDTH; wrap at VN_LOAD_CYCLE-1, not at 2**PAGE_ADDR_BITWIDTH-1.

Optional Feature:
- Macro: VN_LUT_LOADER_CKSUM_EN.
- With the macro, extra ports:
  - expected_cksum_i in 8, reference checksum.
  - cksum_err_o out 1, sticky error flag.
- Checksum accumulator:
  - 8-bit modulo-256 sum of zero-extended accepted entries.
  - Cleared on load_start_i.
  - Compared against expected_cksum_i on the final handshake.
- On mismatch: cksum_err_o sets to 1 and the FSM → IDLE instead of FULL, so the swap is blocked. load_done_o still pulses.
- cksum_err_o clears on the next load_start_i or on rst.
- Without the macro: ports absent, no checksum logic, behaviour as above.

Decomposition:
- Shared package vn_lut_pkg:
  - FSM state enum (IDLE/LOAD/FULL).
  - Default MSG_BITWIDTH, PAGE_ADDR_BITWIDTH, VN_LOAD_CYCLE constants.
  - Checksum width constant (8).
- One natural sub-module: vn_lut_page_counter (modulo-VN_LOAD_CYCLE counter with clear, enable, terminal-count flag).
- Everything else lives in the top.

Test Plan:
- Reset, then load_start_i, then 32 back-to-back entries 0..7 repeating → we_o on 32 cycles with write_addr_o=0x20..0x3F; load_done_o pulses with addr 0x3F; shadow_full_o=1; active_bank_o=0.
- Then bank_swap_i → active_bank_o=1 next cycle, state IDLE. Next load writes addresses 0x00..0x1F.
- entry_valid_i toggled every other cycle during LOAD → exactly 32 writes, no address gaps or duplicates, done only after the 32nd handshake.
- bank_swap_i at entry 10 of LOAD → active_bank_o unchanged; load completes normally.
- load_start_i at entry 20 → counter restarts at 0; next write_addr_o=0x20; 32 further handshakes required for done.
- rst asserted mid-LOAD → we_o=0 and active_bank_o=0 asynchronously, state IDLE.
- With VN_LUT_LOADER_CKSUM_EN: 32 entries all 3'd5 with expected_cksum_i=8'hA0 → no error, FULL. Same entries with expected_cksum_i=8'hA1 → cksum_err_o=1, state IDLE, swap ignored.
